item_dispense_ctrl: RTL

Parametrised, clocked dispense controller for the vending machine. It replaces the fixed 2-to-4 item decoder. The main transaction FSM issues a one-cycle dispense request with an item index; this block validates the request, drives a one-hot dispense output for a programmable number of cycles, and tracks per-item stock with sold-out flags. It sits between the transaction FSM and the item actuators.

---
 rtl/item_dispense_ctrl_if.sv | 26 ++
 rtl/item_dispense_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/item_dispense_ctrl_if.sv
// Dispense request/response bundle between the transaction FSM (master)
// and item_dispense_ctrl (slave).
interface item_dispense_ctrl_if #(
  parameter int NUM_ITEMS = 4,
  parameter int SEL_W     = 2
);
  logic [SEL_W-1:0]     item_select;
  logic                 dispense_req;
  logic                 end_trans;
  logic                 restock;
  logic [NUM_ITEMS-1:0] item_out;
  logic                 busy;
  logic                 done;
  logic                 reject;
  logic [NUM_ITEMS-1:0] sold_out;

  modport master (
    output item_select, dispense_req, end_trans, restock,
    input  item_out, busy, done, reject, sold_out
  );

  modport slave (
    input  item_select, dispense_req, end_trans, restock,
    output item_out, busy, done, reject, sold_out
  );
endinterface

// File: rtl/item_dispense_ctrl.sv
// Validated one-hot item dispense controller with per-item stock tracking.
// Stock counters/sold-out logic are built only when DISPENSE_STOCK_EN is defined.
`ifdef DISPENSE_STOCK_EN
module item_stock_cnt #(
  parameter int STOCK_W    = 4,
  parameter int INIT_STOCK = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dec_i,
  input  logic load_i,
  output logic empty_o
);
  logic [STOCK_W-1:0] stock_q, stock_d;

  // Reload beats a same-cycle decrement; zero never wraps.
  always_comb begin
    stock_d = stock_q;
    if (load_i)                      stock_d = STOCK_W'(INIT_STOCK);
    else if (dec_i && stock_q != '0) stock_d = stock_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stock_q <= STOCK_W'(INIT_STOCK);
    else        stock_q <= stock_d;
  end

  assign empty_o = (stock_q == '0);
endmodule
`endif

module item_dispense_ctrl #(
  parameter int NUM_ITEMS    = 4,
  parameter int SEL_W        = 2,
  parameter int PULSE_CYCLES = 4,
  parameter int STOCK_W      = 4,
  parameter int INIT_STOCK   = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  item_dispense_ctrl_if.slave  bus
);
  localparam int SEL_N = 1 << SEL_W;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DISP = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [NUM_ITEMS-1:0] ONE_HOT0 = {{(NUM_ITEMS-1){1'b0}}, 1'b1};

  logic [1:0]           state_q, state_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 reject_q, reject_d;
  logic [NUM_ITEMS-1:0] empty;
  logic [SEL_N-1:0]     empty_pad;
  logic                 sel_bad;

  // Pad so an out-of-range select can index safely.
  assign empty_pad = SEL_N'(empty);
  assign sel_bad   = (int'(bus.item_select) >= NUM_ITEMS) || empty_pad[bus.item_select];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.dispense_req && !bus.end_trans) begin
          if (sel_bad) begin
            reject_d = 1'b1;
          end else begin
            idx_d   = bus.item_select;
            cnt_d   = 8'(PULSE_CYCLES - 1);
            state_d = S_DISP;
          end
        end
      end
      S_DISP: begin
        if (bus.end_trans)    state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_DONE;
        else                  cnt_d   = cnt_q - 8'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
    end
  end

  // end_trans cuts the actuator drive combinationally in every state.
  assign bus.item_out = (state_q == S_DISP && !bus.end_trans) ? (ONE_HOT0 << idx_q) : '0;
  assign bus.busy     = (state_q == S_DISP) || (state_q == S_DONE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.reject   = reject_q;

`ifdef DISPENSE_STOCK_EN
  logic                 finish;
  logic [NUM_ITEMS-1:0] dec;

  assign finish = (state_q == S_DISP) && (cnt_q == '0) && !bus.end_trans;

  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_stock
    assign dec[g] = finish && (idx_q == SEL_W'(g));
    item_stock_cnt #(
      .STOCK_W    (STOCK_W),
      .INIT_STOCK (INIT_STOCK)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .dec_i   (dec[g]),
      .load_i  (bus.restock),
      .empty_o (empty[g])
    );
  end

  assign bus.sold_out = empty;
`else
  logic unused_restock;
  assign unused_restock = bus.restock;
  assign empty          = '0;
  assign bus.sold_out   = '0;
`endif
endmodule
